// File: rtl/logic_issue_q.sv
// logic_issue_q -- in-order issue queue feeding a combinational logical unit.
// Decode pushes {funct, op1, op2, rd} into a small FIFO. The head entry is
// presented to the logical unit, and its result is captured into a single
// writeback register. The writeback register drains under a valid/ready
// handshake. Results for rd = 0 are popped and dropped, because register x0
// is never written. DEPTH must be a power of two and at least 2, so that the
// pointers wrap naturally at their bit width.
module logic_issue_q #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        rst_n_i,
  input  logic        clk_i,
  input  logic        flush_i,
  // decode side
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_funct_i,
  input  logic [31:0] in_op1_i,
  input  logic [31:0] in_op2_i,
  input  logic [4:0]  in_rd_i,
  // logical unit side
  output logic [3:0]  funct_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  input  logic [31:0] res_i,
  // writeback side
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [3:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
  } entry_t;

  // Queue storage and control state.
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Writeback register.
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;

  entry_t           head;
  entry_t           in_entry;
  logic             head_valid;
  logic             push;
  logic             issue;

  assign in_entry   = '{funct: in_funct_i, op1: in_op1_i, op2: in_op2_i, rd: in_rd_i};
  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);

  // Ready depends only on occupancy, so a same-cycle pop cannot create a
  // combinational path from the writeback handshake to the decode side.
  assign in_ready_o = (count_q < DEPTH_C);
  assign push       = in_valid_i & in_ready_o & ~flush_i;
  assign issue      = head_valid & ~flush_i & (~wb_valid_q | wb_ready_i);

  // The head operands are zeroed when the queue is empty. This keeps the
  // logical unit inputs quiet, including while reset is asserted.
  assign funct_o    = head_valid ? head.funct : '0;
  assign op1_o      = head_valid ? head.op1   : '0;
  assign op2_o      = head_valid ? head.op2   : '0;

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

  // Next-state of pointers and occupancy from push, issue and flush.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, issue})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state of the writeback register. A new non-x0 result wins over the
  // drain. An x0 issue falls through to the drain rule. That issue can only
  // happen when the register is empty or being accepted, so the drain rule
  // gives exactly the required outcome.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (flush_i) begin
      wb_valid_d = 1'b0;
    end else if (issue && (head.rd != 5'd0)) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = head.rd;
      wb_data_d  = res_i;
    end else if (wb_valid_q && wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
  end

  // Control and writeback state registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Entry storage, written at the write pointer on a push.
  // NOTE: the storage array has no reset. Occupancy is tracked by count_q, and stale slots are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_logic_issue_q.sv
// Directed self-checking bench for logic_issue_q with DEPTH = 2.
// The logical unit is modelled combinationally:
//   funct 2 = AND, funct 3 = OR, funct 4 = XOR, and 0 for any other code.
module tb_logic_issue_q;

  logic        rst_n_i, clk_i, flush_i;
  logic        in_valid_i, in_ready_o;
  logic [3:0]  in_funct_i;
  logic [31:0] in_op1_i, in_op2_i;
  logic [4:0]  in_rd_i;
  logic [3:0]  funct_o;
  logic [31:0] op1_o, op2_o, res_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int checks = 0;
  int errors = 0;

  logic_issue_q #(.DEPTH(2)) dut (
    .rst_n_i(rst_n_i), .clk_i(clk_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_funct_i(in_funct_i), .in_op1_i(in_op1_i), .in_op2_i(in_op2_i), .in_rd_i(in_rd_i),
    .funct_o(funct_o), .op1_o(op1_o), .op2_o(op2_o), .res_i(res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Logical unit model.
  always_comb begin
    res_i = '0;
    case (funct_o)
      4'd2:    res_i = op1_o & op2_o;
      4'd3:    res_i = op1_o | op2_o;
      4'd4:    res_i = op1_o ^ op2_o;
      default: res_i = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_valid_i = v;
    in_funct_i = f;
    in_op1_i   = a;
    in_op2_i   = b;
    in_rd_i    = rd;
  endtask

  int pulses;
  logic [4:0]  seen_rd;
  logic [31:0] seen_data;

  initial begin
    rst_n_i    = 1'b0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);

    // ---- reset state ----
    #12;
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_wb_rd",    64'(wb_rd_o),    64'd0);
    check("rst_wb_data",  64'(wb_data_o),  64'd0);
    check("rst_funct",    64'(funct_o),    64'd0);
    check("rst_op1",      64'(op1_o),      64'd0);
    check("rst_op2",      64'(op2_o),      64'd0);
    rst_n_i = 1'b1;
    tick();

    // ---- single op, 2-edge latency ----
    drive(1'b1, 4'd2, 32'hF0F0_0000, 32'h0FF0_FFFF, 5'd5);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    check("single_e1_wb_valid", 64'(wb_valid_o), 64'd0);
    check("single_e1_funct",    64'(funct_o),    64'd2);
    check("single_e1_op1",      64'(op1_o),      64'hF0F0_0000);
    tick();
    check("single_wb_valid", 64'(wb_valid_o), 64'd1);
    check("single_wb_rd",    64'(wb_rd_o),    64'd5);
    check("single_wb_data",  64'(wb_data_o),  64'h00F0_0000);
    tick();
    check("single_drained", 64'(wb_valid_o), 64'd0);

    // ---- backpressure: 1 held + 2 queued, then release ----
    wb_ready_i = 1'b0;
    drive(1'b1, 4'd3, 32'h0000_00F0, 32'h0000_0F00, 5'd1);   // A: OR  -> 0x00000FF0
    tick();
    drive(1'b1, 4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd2);   // B: XOR -> 0xF0F00F0F
    tick();
    drive(1'b1, 4'd2, 32'h1234_5678, 32'h0000_FFFF, 5'd3);   // C: AND -> 0x00005678
    tick();
    drive(1'b1, 4'd3, 32'hDEAD_BEEF, 32'h0, 5'd9);           // D: offered while full
    check("bp_full_ready", 64'(in_ready_o), 64'd0);
    check("bp_wb_valid",   64'(wb_valid_o), 64'd1);
    check("bp_wb_rd",      64'(wb_rd_o),    64'd1);
    check("bp_wb_data",    64'(wb_data_o),  64'h0000_0FF0);
    check("bp_head_funct", 64'(funct_o),    64'd4);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    check("bp_hold_ready", 64'(in_ready_o), 64'd0);
    check("bp_hold_rd",    64'(wb_rd_o),    64'd1);
    check("bp_hold_data",  64'(wb_data_o),  64'h0000_0FF0);
    wb_ready_i = 1'b1;
    tick();
    check("bp_rel1_valid", 64'(wb_valid_o), 64'd1);
    check("bp_rel1_rd",    64'(wb_rd_o),    64'd2);
    check("bp_rel1_data",  64'(wb_data_o),  64'hF0F0_0F0F);
    tick();
    check("bp_rel2_valid", 64'(wb_valid_o), 64'd1);
    check("bp_rel2_rd",    64'(wb_rd_o),    64'd3);
    check("bp_rel2_data",  64'(wb_data_o),  64'h0000_5678);
    tick();
    check("bp_end_valid", 64'(wb_valid_o), 64'd0);
    check("bp_end_ready", 64'(in_ready_o), 64'd1);
    check("bp_end_funct", 64'(funct_o),    64'd0);

    // ---- wrap: 10 back-to-back ops, op k = {4{k}} AND 0x0F0F0F0F, rd = k+1 ----
    for (int c = 0; c < 12; c++) begin
      if (c < 10) drive(1'b1, 4'd2, {4{8'(c)}}, 32'h0F0F_0F0F, 5'(c + 1));
      else        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      tick();
      check("wrap_ready", 64'(in_ready_o), 64'd1);
      if (c >= 1 && c <= 10) begin
        check("wrap_valid", 64'(wb_valid_o), 64'd1);
        check("wrap_rd",    64'(wb_rd_o),    64'(c));
        check("wrap_data",  64'(wb_data_o),  64'({4{8'(c - 1)}}));
      end else begin
        check("wrap_idle", 64'(wb_valid_o), 64'd0);
      end
    end

    // ---- rd = 0 discarded, rd = 7 written ----
    pulses    = 0;
    seen_rd   = '0;
    seen_data = '0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      drive(1'b1, 4'd3, 32'h1, 32'h2, 5'd0);
      else if (c == 1) drive(1'b1, 4'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd7);
      else             drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      tick();
      if (c == 1) check("rd0_discard", 64'(wb_valid_o), 64'd0);
      if (wb_valid_o) begin
        pulses++;
        seen_rd   = wb_rd_o;
        seen_data = wb_data_o;
      end
    end
    check("rd0_pulses", 64'(pulses),    64'd1);
    check("rd0_rd",     64'(seen_rd),   64'd7);
    check("rd0_data",   64'(seen_data), 64'h5555_AAAA);

    // ---- flush with queue full, wb held and a push offered ----
    wb_ready_i = 1'b0;
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h1111_1111, 5'd4);
    tick();
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h2222_2222, 5'd5);
    tick();
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h3333_3333, 5'd6);
    tick();
    check("fl_pre_ready", 64'(in_ready_o), 64'd0);
    check("fl_pre_valid", 64'(wb_valid_o), 64'd1);
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h4444_4444, 5'd8);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    check("fl_wb_valid", 64'(wb_valid_o), 64'd0);
    check("fl_ready",    64'(in_ready_o), 64'd1);
    check("fl_funct",    64'(funct_o),    64'd0);
    check("fl_op2",      64'(op2_o),      64'd0);
    wb_ready_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wb_valid_o) pulses++;
    end
    check("fl_no_wb", 64'(pulses), 64'd0);

    // ---- async reset between edges with 2 queued ----
    wb_ready_i = 1'b0;
    drive(1'b1, 4'd3, 32'h0000_0001, 32'h0000_0010, 5'd10);
    tick();
    drive(1'b1, 4'd3, 32'h0000_0002, 32'h0000_0020, 5'd11);
    tick();
    drive(1'b1, 4'd3, 32'h0000_0003, 32'h0000_0030, 5'd12);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
    check("ar_pre_valid", 64'(wb_valid_o), 64'd1);
    check("ar_pre_ready", 64'(in_ready_o), 64'd0);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("ar_wb_valid", 64'(wb_valid_o), 64'd0);
    check("ar_ready",    64'(in_ready_o), 64'd1);
    check("ar_wb_rd",    64'(wb_rd_o),    64'd0);
    check("ar_wb_data",  64'(wb_data_o),  64'd0);
    check("ar_op1",      64'(op1_o),      64'd0);
    #1;
    rst_n_i    = 1'b1;
    wb_ready_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wb_valid_o) pulses++;
    end
    check("ar_no_wb", 64'(pulses), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
